board_editor: RTL and testbench

BOARD_EDITOR -- requirements
Module: board_editor

---
 rtl/board_editor_pkg.sv | 25 ++
 rtl/board_editor_if.sv | 24 ++
 rtl/board_editor_step_timer.sv | 60 ++++++
 rtl/board_editor.sv | 119 +++++++++++
 tb/tb_board_editor.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/board_editor_pkg.sv
// Shared constants, FSM state encoding and cell-address helper for the board editor.
package board_editor_pkg;

  localparam int LOG_BOARD_SIZE = 4;
  localparam int BOARD_SIZE     = 1 << LOG_BOARD_SIZE;
  localparam int LOG_MAX_SPEED  = 3;
  localparam int MAX_SPEED      = 1 << LOG_MAX_SPEED;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    STEP = 3'd4
  } state_e;

  // Row-major cell index: y*BOARD_SIZE + x.
  function automatic logic [2*LOG_BOARD_SIZE-1:0] cell_addr(
    input logic [LOG_BOARD_SIZE-1:0] x,
    input logic [LOG_BOARD_SIZE-1:0] y
  );
    return {y, x};
  endfunction

endpackage

// File: rtl/board_editor_if.sv
// Board memory bus between the editor (master) and the cell store (slave).
interface board_editor_if;
  import board_editor_pkg::*;

  logic [2*LOG_BOARD_SIZE-1:0] mem_addr_out;
  logic                        mem_we_out;
  logic                        mem_data_out;
  logic                        mem_data_in;

  modport master (
    output mem_addr_out,
    output mem_we_out,
    output mem_data_out,
    input  mem_data_in
  );

  modport slave (
    input  mem_addr_out,
    input  mem_we_out,
    input  mem_data_out,
    output mem_data_in
  );

endinterface

// File: rtl/board_editor_step_timer.sv
// Free-running prescaler plus speed-scaled tick counter; holds a single
// coalescing "step due" flag until the editor acknowledges it with clear_in.
module step_timer
  import board_editor_pkg::*;
#(
  parameter int LOG_TICK = 22
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [LOG_MAX_SPEED-1:0] speed_in,
  input  logic                     clear_in,
  output logic                     due_out
);

  localparam logic [LOG_MAX_SPEED:0] MAX_SPEED_W = (LOG_MAX_SPEED+1)'(MAX_SPEED);

  logic [LOG_TICK-1:0]      r_presc;
  logic [LOG_MAX_SPEED-1:0] r_tick_cnt;
  logic                     r_due;
  logic                     w_tick;
  logic                     w_run;
  logic [LOG_MAX_SPEED:0]   w_cnt_inc;
  logic [LOG_MAX_SPEED:0]   w_limit;
  logic                     w_hit;

  // Tick qualification and threshold compare; speed is read live every tick.
  always_comb begin
    w_tick    = &r_presc;
    w_run     = (speed_in != {LOG_MAX_SPEED{1'b0}});
    w_cnt_inc = {1'b0, r_tick_cnt} + {{LOG_MAX_SPEED{1'b0}}, 1'b1};
    w_limit   = MAX_SPEED_W - {1'b0, speed_in};
    w_hit     = (w_cnt_inc >= w_limit);
  end

  // Prescaler: wraps every 2**LOG_TICK cycles, tick on all-ones.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_presc <= {LOG_TICK{1'b0}};
    else        r_presc <= r_presc + {{(LOG_TICK-1){1'b0}}, 1'b1};
  end

  // Tick counter: held at zero while paused, restarts after each due step.
  always_ff @(posedge clk_in) begin
    if (rst_in)                r_tick_cnt <= {LOG_MAX_SPEED{1'b0}};
    else if (!w_run)           r_tick_cnt <= {LOG_MAX_SPEED{1'b0}};
    else if (w_tick && w_hit)  r_tick_cnt <= {LOG_MAX_SPEED{1'b0}};
    else if (w_tick)           r_tick_cnt <= w_cnt_inc[LOG_MAX_SPEED-1:0];
    else                       r_tick_cnt <= r_tick_cnt;
  end

  // Pending-step flag; a new due step wins over a same-cycle acknowledge.
  always_ff @(posedge clk_in) begin
    if (rst_in)                        r_due <= 1'b0;
    else if (w_tick && w_run && w_hit) r_due <= 1'b1;
    else if (clear_in)                 r_due <= 1'b0;
    else                               r_due <= r_due;
  end

  assign due_out = r_due;

endmodule

// File: rtl/board_editor.sv
// Board editor: toggles the clicked cell by read-modify-write and issues
// generation steps at the selected speed, edits taking priority over steps.
module board_editor
  import board_editor_pkg::*;
#(
  parameter int LOG_TICK = 22
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      click_in,
  input  logic [LOG_MAX_SPEED-1:0]  speed_in,
  input  logic [LOG_BOARD_SIZE-1:0] cursor_x_in,
  input  logic [LOG_BOARD_SIZE-1:0] cursor_y_in,
  input  logic                      engine_done_in,
  output logic                      step_out,
  output logic                      busy_out,
  board_editor_if.master            mem
);

  localparam int AW = 2*LOG_BOARD_SIZE;

  state_e        r_state;
  state_e        w_next;
  logic          w_clear_step;
  logic          w_due;
  logic          w_edge;
  logic          r_click_prev;
  logic          r_edit_pend;
  logic [AW-1:0] r_addr_latch;
  logic [AW-1:0] r_addr;
  logic          r_we;
  logic          r_wdata;
  logic          r_step;
  logic          r_busy;

  step_timer #(.LOG_TICK(LOG_TICK)) u_step_timer (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .speed_in (speed_in),
    .clear_in (w_clear_step),
    .due_out  (w_due)
  );

  assign w_edge = click_in & ~r_click_prev;

  // Click edge detect and edit request latch; extra edges while pending are dropped.
  always_ff @(posedge clk_in) begin
    r_click_prev <= click_in;
    if (rst_in) begin
      r_edit_pend  <= 1'b0;
      r_addr_latch <= {AW{1'b0}};
    end else if (w_edge && !r_edit_pend) begin
      r_edit_pend  <= 1'b1;
      r_addr_latch <= cell_addr(cursor_x_in, cursor_y_in);
    end else if (r_state == WR) begin
      r_edit_pend  <= 1'b0;
      r_addr_latch <= r_addr_latch;
    end else begin
      r_edit_pend  <= r_edit_pend;
      r_addr_latch <= r_addr_latch;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; the step acknowledge fires on the IDLE->STEP transition.
  always_comb begin
    w_next       = r_state;
    w_clear_step = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_edit_pend) begin
          w_next = RD;
        end else if (w_due) begin
          w_next       = STEP;
          w_clear_step = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      RD:   w_next = WAIT;
      WAIT: w_next = WR;
      WR:   w_next = IDLE;
      STEP: begin
        if (engine_done_in) w_next = IDLE;
        else                w_next = STEP;
      end
      default: w_next = IDLE;
    endcase
  end

  // Registered outputs, decoded from the next state so they line up with it.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_step  <= 1'b0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_addr  <= {AW{1'b0}};
      r_wdata <= 1'b0;
    end else begin
      r_step  <= w_clear_step;
      r_we    <= (w_next == WR);
      r_busy  <= (w_next != IDLE);
      r_addr  <= (w_next == RD) ? r_addr_latch : r_addr;
      r_wdata <= (r_state == WAIT) ? ~mem.mem_data_in : r_wdata;
    end
  end

  assign step_out         = r_step;
  assign busy_out         = r_busy;
  assign mem.mem_addr_out = r_addr;
  assign mem.mem_we_out   = r_we;
  assign mem.mem_data_out = r_wdata;

endmodule

// File: tb/tb_board_editor.sv
// Directed bench for board_editor with LOG_TICK=2: step pacing, pause,
// cell toggling, edit/step arbitration, click during STEP, reset in WAIT.
module tb_board_editor;

  logic       clk = 1'b0;
  logic       rst;
  logic       click;
  logic       done;
  logic [2:0] speed;
  logic [3:0] cx;
  logic [3:0] cy;
  logic       step;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_delay = 1;

  int         step_q[$];
  int         we_cnt = 0;
  int         we_cyc = -1;
  logic [7:0] we_addr = 8'h00;
  logic       we_data = 1'b0;
  logic       memory [0:255];
  logic [7:0] prev_addr;

  board_editor_if mem_bus ();

  board_editor #(.LOG_TICK(2)) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .click_in       (click),
    .speed_in       (speed),
    .cursor_x_in    (cx),
    .cursor_y_in    (cy),
    .engine_done_in (done),
    .step_out       (step),
    .busy_out       (busy),
    .mem            (mem_bus)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Cell store with one-cycle read latency, plus step/write recorders.
  initial begin
    for (int i = 0; i < 256; i++) memory[i] = 1'b0;
    prev_addr = 8'h00;
    mem_bus.mem_data_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      mem_bus.mem_data_in = memory[prev_addr];
      if (mem_bus.mem_we_out === 1'b1) begin
        memory[mem_bus.mem_addr_out] = mem_bus.mem_data_out;
        we_cnt++;
        we_cyc  = cyc;
        we_addr = mem_bus.mem_addr_out;
        we_data = mem_bus.mem_data_out;
      end
      prev_addr = mem_bus.mem_addr_out;
      if (step === 1'b1) step_q.push_back(cyc);
    end
  end

  // Life-engine stand-in: one done pulse done_delay cycles after each step.
  initial begin
    done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (step === 1'b1) begin
        repeat (done_delay) begin
          @(posedge clk);
          #2;
        end
        done = 1'b1;
        @(posedge clk);
        #2;
        done = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_step(input string tag, input int budget, output int s);
    int n0;
    n0 = step_q.size();
    s  = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (step_q.size() > n0) begin
        s = step_q[n0];
        break;
      end
    end
    check({tag, "_found"}, 32'(s >= 0), 32'd1);
  endtask

  task automatic period_check(input string tag, input int period, input int min_pulses);
    check({tag, "_count"}, 32'(step_q.size() >= min_pulses), 32'd1);
    for (int i = 1; i < step_q.size(); i++)
      check({tag, "_period"}, 32'(step_q[i] - step_q[i-1]), 32'(period));
  endtask

  initial begin
    int e;
    int s;
    int base;
    int n0;

    rst = 1'b1; click = 1'b0; speed = 3'd0; cx = 4'd0; cy = 4'd0;
    run(3);
    check("rst_step", 32'(step), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we",   32'(mem_bus.mem_we_out), 32'd0);
    check("rst_addr", 32'(mem_bus.mem_addr_out), 32'h00);
    check("rst_data", 32'(mem_bus.mem_data_out), 32'd0);

    // Speed 7: one step per tick (4 cycles); speed 6: every other tick.
    rst = 1'b0; speed = 3'd7;
    run(8); step_q.delete(); run(40);
    period_check("spd7", 4, 5);
    speed = 3'd6;
    run(12); step_q.delete(); run(64);
    period_check("spd6", 8, 5);

    // Paused: no steps at all.
    speed = 3'd0;
    run(12); step_q.delete(); run(200);
    check("spd0_pulses", 32'(step_q.size()), 32'd0);
    check("spd0_busy", 32'(busy), 32'd0);

    // Click at (3,5) on a dead cell: write 1 to 0x53 at edge+4, then toggle back.
    cx = 4'd3; cy = 4'd5; base = we_cnt;
    click = 1'b1; e = cyc;
    run(3);
    check("edit1_busy", 32'(busy), 32'd1);
    check("edit1_early", 32'(we_cnt), 32'(base));
    run(7);
    check("edit1_cnt",  32'(we_cnt), 32'(base + 1));
    check("edit1_cyc",  32'(we_cyc), 32'(e + 4));
    check("edit1_addr", 32'(we_addr), 32'h53);
    check("edit1_data", 32'(we_data), 32'd1);
    click = 1'b0; run(3);
    click = 1'b1; e = cyc;
    run(10);
    check("edit2_cnt",  32'(we_cnt), 32'(base + 2));
    check("edit2_cyc",  32'(we_cyc), 32'(e + 4));
    check("edit2_addr", 32'(we_addr), 32'h53);
    check("edit2_data", 32'(we_data), 32'd0);
    click = 1'b0; run(3);

    // Click edge in the tick cycle that raises step_pend: write first, one step after.
    cx = 4'd1; cy = 4'd2; speed = 3'd7;
    step_q.delete();
    wait_step("coll_sync", 40, s);
    run(2);
    click = 1'b1; base = we_cnt;
    run(1);
    speed = 3'd0; n0 = step_q.size();
    run(30);
    click = 1'b0;
    check("coll_we_cnt", 32'(we_cnt), 32'(base + 1));
    check("coll_we_cyc", 32'(we_cyc), 32'(s + 6));
    check("coll_addr",   32'(we_addr), 32'h21);
    check("coll_data",   32'(we_data), 32'd1);
    check("coll_steps",  32'(step_q.size() - n0), 32'd1);
    check("coll_step_cyc", 32'((step_q.size() > n0) ? step_q[n0] : -1), 32'(s + 8));
    run(3);

    // Click during STEP with a slow engine: write only after done.
    done_delay = 20;
    cx = 4'd7; cy = 4'hA; speed = 3'd7;
    wait_step("dly_sync", 40, s);
    speed = 3'd0; base = we_cnt;
    run(2);
    click = 1'b1;
    run(8);
    check("dly_busy", 32'(busy), 32'd1);
    run(10);
    check("dly_no_early", 32'(we_cnt), 32'(base));
    run(8);
    click = 1'b0;
    check("dly_we_cnt", 32'(we_cnt), 32'(base + 1));
    check("dly_we_cyc", 32'(we_cyc), 32'(s + 24));
    check("dly_addr",   32'(we_addr), 32'hA7);
    check("dly_data",   32'(we_data), 32'd1);
    done_delay = 1;
    run(5);

    // Reset in WAIT with the button held: no write, no edit afterwards.
    cx = 4'd3; cy = 4'd5; base = we_cnt;
    click = 1'b1;
    run(3);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(25);
    check("rstw_no_write", 32'(we_cnt), 32'(base));
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_step", 32'(step), 32'd0);
    click = 1'b0;
    run(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
